memory_access_stage: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM register and the MEM/WB boundary.

---
 rtl/memory_access_stage_if.sv | 44 ++++
 rtl/memory_access_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// ---------------------------------------------------------------------------
// memory_access_stage_if
//   Data-memory request/response bundle between the MEM-stage load/store
//   unit (master) and the data memory (slave).
//
//   mem_req    master->slave  request valid
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  lane-replicated store data
//   mem_be     master->slave  byte enables (0000 for reads)
//   mem_ready  slave->master  request accepted/completed this cycle
//   mem_rdata  slave->master  read word, valid with mem_ready on a read
// ---------------------------------------------------------------------------
interface memory_access_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//   MEM-stage load/store unit. Takes the EX/MEM fields, performs byte/half/
//   word loads and stores over a req/ready handshake, stalls the upstream
//   pipeline while the memory inserts wait states, and registers the MEM/WB
//   fields used by the writeback mux.
//
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   RegWriteM..PCPlus4M  EX/MEM fields (held stable by upstream while StallM)
//   dmem              data-memory handshake (master side)
//   StallM            freeze PC, IF/ID, ID/EX and EX/MEM
//   *W                registered MEM/WB fields, MisalignW flags a trapped
//                     misaligned or reserved-encoding access
//
//   Byte-lane logic assumes four 8-bit lanes, i.e. DATA_WIDTH = 32.
// ---------------------------------------------------------------------------
module memory_access_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [1:0]            ResultSrcM,
    input  logic [4:0]            RdM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,

    memory_access_stage_if.master dmem,

    output logic                  StallM,

    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic                  MisalignW
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;

    logic                  is_access;
    logic                  funct_legal;
    logic                  offset_ok;
    logic                  misalign;
    logic                  issue;

    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] word_addr;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;

    // Copies of the request taken when entering WAIT so the bus stays
    // stable even if something upstream glitches during the stall.
    logic                  hold_we;
    logic [DATA_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic [3:0]            hold_be;

    assign is_access = MemReadM | MemWriteM;
    assign word_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

    // Legal encodings: SB/SH/SW for stores, LB/LH/LW/LBU/LHU for loads.
    // Anything else is reported as a misaligned access so it traps
    // instead of touching memory.
    always_comb begin
        funct_legal = 1'b0;
        case (Funct3M)
            3'b000, 3'b001, 3'b010: funct_legal = 1'b1;
            3'b100, 3'b101:         funct_legal = MemReadM;
            default:                funct_legal = 1'b0;
        endcase

        offset_ok = 1'b1;
        case (Funct3M[1:0])
            2'b01:   offset_ok = ~ALUResultM[0];
            2'b10:   offset_ok = (ALUResultM[1:0] == 2'b00);
            default: offset_ok = 1'b1;
        endcase

        misalign = is_access & ~(funct_legal & offset_ok);
    end

    assign issue = is_access & ~misalign;

    // Store lane steering: data is replicated across every lane so the
    // memory only needs the byte enables to pick the right bytes.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << ALUResultM[1:0];
                lane_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                lane_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = WriteDataM;
            end
        endcase
        if (!MemWriteM) begin
            lane_be = 4'b0000;
        end
    end

    // Bus drive. The rst_n gate drops the request the instant reset is
    // asserted, even in the middle of a wait.
    always_comb begin
        if (state == WAIT) begin
            dmem.mem_req   = rst_n;
            dmem.mem_we    = hold_we;
            dmem.mem_addr  = hold_addr;
            dmem.mem_wdata = hold_wdata;
            dmem.mem_be    = hold_be;
        end else begin
            dmem.mem_req   = rst_n & issue;
            dmem.mem_we    = MemWriteM;
            dmem.mem_addr  = word_addr;
            dmem.mem_wdata = lane_wdata;
            dmem.mem_be    = lane_be;
        end
    end

    assign StallM = dmem.mem_req & ~dmem.mem_ready;

    // Load extraction: pick the addressed byte/half from the returned
    // word, then sign- or zero-extend according to funct3[2].
    always_comb begin
        byte_sel = dmem.mem_rdata[7:0];
        case (ALUResultM[1:0])
            2'b00: byte_sel = dmem.mem_rdata[7:0];
            2'b01: byte_sel = dmem.mem_rdata[15:8];
            2'b10: byte_sel = dmem.mem_rdata[23:16];
            2'b11: byte_sel = dmem.mem_rdata[31:24];
            default: byte_sel = dmem.mem_rdata[7:0];
        endcase

        half_sel = ALUResultM[1] ? dmem.mem_rdata[31:16] : dmem.mem_rdata[15:0];

        load_data = '0;
        case (Funct3M)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0000, half_sel};
            3'b010:  load_data = dmem.mem_rdata;
            default: load_data = '0;
        endcase
    end

    // Handshake FSM. A zero-wait access completes in IDLE; otherwise the
    // request is captured and held in WAIT until mem_ready. Returning to
    // IDLE coincides with the pipeline advancing, so the same instruction
    // is never presented twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && !dmem.mem_ready) begin
                        state      <= WAIT;
                        hold_we    <= MemWriteM;
                        hold_addr  <= word_addr;
                        hold_wdata <= lane_wdata;
                        hold_be    <= lane_be;
                    end
                end
                WAIT: begin
                    if (dmem.mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register. A stall cycle becomes a bubble; a misaligned access
    // still moves down the pipe but with its register write suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (MemReadM && !misalign) ? load_data : '0;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= misalign;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_access_stage
//   Directed scenarios followed by a randomized instruction stream. Expected
//   bus fields and writeback values come from arithmetic reference functions
//   and a small word-array memory kept in the bench.
// ---------------------------------------------------------------------------
module tb_memory_access_stage;

    logic        clk;
    logic        rst_n;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        MisalignW;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];

    memory_access_stage_if #(.DATA_WIDTH(32)) dmem_bus ();

    memory_access_stage #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .dmem       (dmem_bus),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .MisalignW  (MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rules written as plain arithmetic on access size.
    function automatic logic model_misalign(input logic mr, input logic mw,
                                            input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!mr && !mw) return 1'b0;
        if (mw && f3 > 3'd2) return 1'b1;
        if (mr && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic mw, input logic [2:0] f3,
                                            input logic [31:0] a);
        int size;
        int mask;
        if (!mw) return 4'b0000;
        size = 1 << f3[1:0];
        mask = (1 << size) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int size;
        logic [31:0] mask;
        logic [31:0] val;
        size = 1 << f3[1:0];
        if (size == 4) return rdata;
        mask = (32'h1 << (8 * size)) - 32'h1;
        val  = (rdata >> (8 * (a % 4))) & mask;
        if (!f3[2] && val[8 * size - 1]) val = val | ~mask;
        return val;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_w_zero(input string tag);
        check_output({tag, "_regwrite"}, {31'b0, RegWriteW}, 32'd0);
        check_output({tag, "_resultsrc"}, {30'b0, ResultSrcW}, 32'd0);
        check_output({tag, "_rd"}, {27'b0, RdW}, 32'd0);
        check_output({tag, "_aluresult"}, ALUResultW, 32'd0);
        check_output({tag, "_readdata"}, ReadDataW, 32'd0);
        check_output({tag, "_pcplus4"}, PCPlus4W, 32'd0);
        check_output({tag, "_misalign"}, {31'b0, MisalignW}, 32'd0);
    endtask

    task automatic drive_idle();
        RegWriteM  = 1'b0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        ResultSrcM = 2'b00;
        RdM        = 5'd0;
        Funct3M    = 3'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        PCPlus4M   = 32'd0;
    endtask

    // Presents one instruction at a negedge, plays the memory with 'waits'
    // wait states, and checks the bus, stall and writeback. Returns at the
    // negedge after the instruction has been written into MEM/WB.
    task automatic apply_stimulus(input logic rw, input logic mw, input logic mr,
                                  input logic [1:0] rs, input logic [4:0] rd,
                                  input logic [2:0] f3, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [31:0] pc4,
                                  input int waits, input logic [31:0] rdata);
        logic mis;
        logic go;
        logic [3:0] be_exp;
        logic [31:0] wdata_exp;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemReadM   = mr;
        ResultSrcM = rs;
        RdM        = rd;
        Funct3M    = f3;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
        mis        = model_misalign(mr, mw, f3, alu);
        go         = (mr | mw) & ~mis;
        be_exp     = model_be(mw, f3, alu);
        wdata_exp  = model_wdata(f3, wd);
        if (go) begin
            dmem_bus.mem_ready = (waits == 0);
            dmem_bus.mem_rdata = (waits == 0) ? rdata : $urandom;
        end else begin
            dmem_bus.mem_ready = 1'($urandom % 2);
            dmem_bus.mem_rdata = $urandom;
        end
        #1;
        if (go) begin
            check_output("req", {31'b0, dmem_bus.mem_req}, 32'd1);
            check_output("we", {31'b0, dmem_bus.mem_we}, {31'b0, mw});
            check_output("addr", dmem_bus.mem_addr, alu & 32'hFFFF_FFFC);
            check_output("be", {28'b0, dmem_bus.mem_be}, {28'b0, be_exp});
            if (mw) check_output("wdata", dmem_bus.mem_wdata, wdata_exp);
            check_output("stall", {31'b0, StallM}, {31'b0, waits != 0});
            for (int k = 0; k < waits; k++) begin
                @(negedge clk);
                check_output("bubble_regwrite", {31'b0, RegWriteW}, 32'd0);
                check_output("bubble_misalign", {31'b0, MisalignW}, 32'd0);
                check_output("hold_req", {31'b0, dmem_bus.mem_req}, 32'd1);
                check_output("hold_we", {31'b0, dmem_bus.mem_we}, {31'b0, mw});
                check_output("hold_addr", dmem_bus.mem_addr, alu & 32'hFFFF_FFFC);
                check_output("hold_be", {28'b0, dmem_bus.mem_be}, {28'b0, be_exp});
                if (mw) check_output("hold_wdata", dmem_bus.mem_wdata, wdata_exp);
                if (k == waits - 1) begin
                    dmem_bus.mem_ready = 1'b1;
                    dmem_bus.mem_rdata = rdata;
                end else begin
                    dmem_bus.mem_rdata = $urandom;
                end
                #1;
                check_output("wait_stall", {31'b0, StallM}, {31'b0, k != waits - 1});
            end
        end else begin
            check_output("noreq", {31'b0, dmem_bus.mem_req}, 32'd0);
            check_output("nostall", {31'b0, StallM}, 32'd0);
        end
        @(negedge clk);
        check_output("w_regwrite", {31'b0, RegWriteW}, {31'b0, rw & ~mis});
        check_output("w_resultsrc", {30'b0, ResultSrcW}, {30'b0, rs});
        check_output("w_rd", {27'b0, RdW}, {27'b0, rd});
        check_output("w_aluresult", ALUResultW, alu);
        check_output("w_pcplus4", PCPlus4W, pc4);
        check_output("w_misalign", {31'b0, MisalignW}, {31'b0, mis});
        check_output("w_readdata", ReadDataW, (mr && !mis) ? model_load(f3, alu, rdata) : 32'd0);
    endtask

    initial begin
        logic       kind_r;
        logic       kind_w;
        logic [2:0] f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0] be;
        logic [31:0] lanes;
        int         idx;

        for (int i = 0; i < 16; i++) model_mem[i] = $urandom;

        // Reset state with a load presented: no request may escape.
        rst_n = 1'b0;
        drive_idle();
        MemReadM = 1'b1;
        Funct3M  = 3'b010;
        dmem_bus.mem_ready = 1'b0;
        dmem_bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_req", {31'b0, dmem_bus.mem_req}, 32'd0);
        check_output("reset_stall", {31'b0, StallM}, 32'd0);
        check_w_zero("reset");
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: LW zero-wait.
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'b01, 5'd5, 3'b010, 32'h0000_0100,
                       32'd0, 32'h0000_0004, 0, 32'hDEAD_BEEF);
        check_output("t1_readdata", ReadDataW, 32'hDEAD_BEEF);
        // 2: LB with three wait states, sign-extended top byte.
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'b01, 5'd6, 3'b000, 32'h0000_0103,
                       32'd0, 32'h0000_0008, 3, 32'h80FF_FFFF);
        check_output("t2_readdata", ReadDataW, 32'hFFFF_FF80);
        // 3: SH to the upper half.
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 3'b001, 32'h0000_0202,
                       32'h1234_ABCD, 32'h0000_000C, 0, 32'd0);
        // 4: misaligned LHU.
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'b01, 5'd7, 3'b101, 32'h0000_0001,
                       32'd0, 32'h0000_0010, 0, 32'h1111_2222);
        check_output("t4_misalign", {31'b0, MisalignW}, 32'd1);
        // Non-memory pass-through.
        apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd9, 3'b011, 32'hCAFE_0001,
                       32'd0, 32'h0000_0014, 0, 32'd0);

        // 5: reset in the middle of a wait, then a clean SW.
        RegWriteM  = 1'b1;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b1;
        ResultSrcM = 2'b01;
        RdM        = 5'd3;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0000_0104;
        WriteDataM = 32'd0;
        PCPlus4M   = 32'h0000_0018;
        dmem_bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check_output("t5_waiting_stall", {31'b0, StallM}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("t5_reset_req", {31'b0, dmem_bus.mem_req}, 32'd0);
        check_output("t5_reset_stall", {31'b0, StallM}, 32'd0);
        check_w_zero("t5_reset");
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 3'b010, 32'h0000_0300,
                       32'h5566_7788, 32'h0000_001C, 0, 32'd0);

        // Randomized stream against the word-array memory.
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 2);
            kind_r = (idx == 1);
            kind_w = (idx == 2);
            f3  = 3'($urandom_range(0, 7));
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            wd  = $urandom;
            idx = int'(alu[5:2]);
            apply_stimulus(1'($urandom % 2), kind_w, kind_r, 2'($urandom % 4),
                           5'($urandom % 32), f3, alu, wd, $urandom,
                           $urandom_range(0, 3), model_mem[idx]);
            if (kind_w && !model_misalign(1'b0, 1'b1, f3, alu)) begin
                be    = model_be(1'b1, f3, alu);
                lanes = model_wdata(f3, wd);
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[idx][8*b +: 8] = lanes[8*b +: 8];
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
